// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between the main pipeline (req0) and the address/PC unit (req1).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_issue_arbiter #(
    parameter int          DW       = 16,
    parameter logic [2:0]  FLAG_RST = 3'b000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [3:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [3:0]    req1_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic [2:0]    flags_q,
    output logic          halted
);

    typedef enum logic [1:0] {IDLE, FULL, HALT} state_t;

    state_t        r_state;
    logic          r_valid;
    logic          r_id;
    logic [DW-1:0] r_data;
    logic [2:0]    r_flags;
    logic          r_halted;

    logic w_free;
    logic w_pick1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_acc;
    logic w_hlt;
    logic w_wr_nvz;
    logic w_wr_z;

    // rsp_ready feeds straight into the request readies (one combinational level)
    assign w_free = rst_n &&
                    (r_state == IDLE ||
                     (r_state == FULL && rsp_ready));

`ifdef ALU_ARB_RR_EN
    logic r_last;

    assign w_pick1 = req1_valid && (!req0_valid || !r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_acc) begin
            r_last <= w_gnt1;
        end
    end
`else
    assign w_pick1 = req1_valid && !req0_valid;
`endif

    assign w_gnt1 = w_free && w_pick1;
    assign w_gnt0 = w_free && req0_valid && !w_pick1;
    assign w_acc  = w_gnt0 || w_gnt1;
    assign w_hlt  = w_gnt0 && (req0_op == 4'hF);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Idle mux parks on req0 so the ALU inputs do not toggle between sources
    assign alu_a      = w_gnt1 ? req1_a  : req0_a;
    assign alu_b      = w_gnt1 ? req1_b  : req0_b;
    assign alu_opcode = w_gnt1 ? req1_op : req0_op;

    always_comb begin
        w_wr_nvz = 1'b0;
        w_wr_z   = 1'b0;
        unique case (req0_op)
            4'h0, 4'h1:             w_wr_nvz = 1'b1;
            4'h2, 4'h4, 4'h5, 4'h6: w_wr_z   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_id     <= 1'b0;
            r_data   <= '0;
            r_halted <= 1'b0;
        end else if (w_hlt) begin
            r_state  <= HALT;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
        end else if (w_acc) begin
            r_state <= FULL;
            r_valid <= 1'b1;
            r_id    <= w_gnt1;
            r_data  <= alu_out;
        end else if (r_state == FULL && rsp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= FLAG_RST;
        end else if (w_gnt0 && w_wr_nvz) begin
            r_flags <= alu_flags;
        end else if (w_gnt0 && w_wr_z) begin
            r_flags[0] <= alu_flags[0];
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign flags_q   = r_flags;
    assign halted    = r_halted;

endmodule
